// File: rtl/addr_latch_n_if.sv
// Address-latch bus: source select, flattened sources, operation and index in;
// latched address and page-cross flag out.
interface addr_latch_n_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0]      addr_sel;
  logic [NSRC*WIDTH-1:0] addr_in;
  logic [1:0]            mode;
  logic [7:0]            idx;
  logic [WIDTH-1:0]      a;
  logic                  page_cross;

  modport master (output addr_sel, addr_in, mode, idx, input a, page_cross);
  modport slave  (input addr_sel, addr_in, mode, idx, output a, page_cross);
endinterface

// File: rtl/addr_latch_n.sv
// Falling-edge address register with load/hold/post-increment/indexed-add
// operations and a one-update 6502-style page-cross pulse.
module addr_latch_n #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int SEL_W = 2
) (
  input logic           clk,
  input logic           reset_n,
  addr_latch_n_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_INC   = 2'b10,
    MODE_INDEX = 2'b11
  } mode_e;

  generate
    if (WIDTH < 9 || NSRC < 2 || NSRC > 16 || (1 << SEL_W) < NSRC) begin : g_bad_params
      $error("addr_latch_n: illegal WIDTH/NSRC/SEL_W combination");
    end
  endgenerate

  logic [WIDTH-1:0] a_q, a_d;
  logic             pc_q, pc_d;
  logic [WIDTH-1:0] src;
  logic             idxCarry;

  // Out-of-range selects fall through to the last source.
  always_comb begin
    src = bus.addr_in[(NSRC-1)*WIDTH +: WIDTH];
    for (int k = 0; k < NSRC - 1; k++) begin
      if (bus.addr_sel == SEL_W'(k)) src = bus.addr_in[k*WIDTH +: WIDTH];
    end
  end

  assign idxCarry = ({1'b0, src[7:0]} + {1'b0, bus.idx}) > 9'h0FF;

  always_comb begin
    a_d  = a_q;
    pc_d = 1'b0;
    case (mode_e'(bus.mode))
      MODE_LOAD:  a_d = src;
      MODE_HOLD:  a_d = a_q;
      MODE_INC: begin
        a_d  = a_q + WIDTH'(1);
        pc_d = (a_q[7:0] == 8'hFF);
      end
      MODE_INDEX: begin
        a_d  = src + WIDTH'(bus.idx);
        pc_d = idxCarry;
      end
      default: a_d = a_q;
    endcase
  end

  // Falling-edge update keeps the timing of the original address latch.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      a_q  <= '0;
      pc_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      pc_q <= pc_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.page_cross = pc_q;

endmodule

// File: tb/tb_addr_latch_n.sv
// Scoreboard bench for addr_latch_n: three parameterisations driven with directed
// vectors plus a reference-model stream on the 24-bit instance.
module tb_addr_latch_n;

  typedef struct {
    int         dutId;
    logic [23:0] expA;
    logic        expPc;
    string       name;
  } scb_entry_t;

  logic clk;
  logic rstN;
  logic [191:0] srcBus;
  scb_entry_t expQ[$];
  scb_entry_t curEntry;
  int compareCount;
  int failCount;

  addr_latch_n_if #(.WIDTH(16), .NSRC(4), .SEL_W(2)) if16 ();
  addr_latch_n_if #(.WIDTH(16), .NSRC(3), .SEL_W(2)) if3 ();
  addr_latch_n_if #(.WIDTH(24), .NSRC(8), .SEL_W(3)) if24 ();

  addr_latch_n #(.WIDTH(16), .NSRC(4), .SEL_W(2)) dut16 (.clk(clk), .reset_n(rstN), .bus(if16.slave));
  addr_latch_n #(.WIDTH(16), .NSRC(3), .SEL_W(2)) dut3  (.clk(clk), .reset_n(rstN), .bus(if3.slave));
  addr_latch_n #(.WIDTH(24), .NSRC(8), .SEL_W(3)) dut24 (.clk(clk), .reset_n(rstN), .bus(if24.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An unknown operation code outside reset is illegal stimulus.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      assert (!$isunknown(if16.mode) && !$isunknown(if3.mode) && !$isunknown(if24.mode))
        else $error("[TB] mode is X while out of reset");
    end
  end

  task automatic applyStimulus(input int dutId, input logic [2:0] sel, input logic [1:0] mode,
                               input logic [7:0] idx, input logic rstVal,
                               input logic [23:0] expA, input logic expPc, input string name);
    scb_entry_t e;
    @(posedge clk);
    rstN = rstVal;
    case (dutId)
      0: begin if16.addr_sel = sel[1:0]; if16.mode = mode; if16.idx = idx; if16.addr_in = srcBus[63:0]; end
      1: begin if3.addr_sel = sel[1:0]; if3.mode = mode; if3.idx = idx; if3.addr_in = srcBus[47:0]; end
      default: begin if24.addr_sel = sel; if24.mode = mode; if24.idx = idx; if24.addr_in = srcBus; end
    endcase
    @(negedge clk);
    #1;
    e.dutId = dutId;
    e.expA  = expA;
    e.expPc = expPc;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input scb_entry_t e);
    logic [23:0] actA;
    logic        actPc;
    case (e.dutId)
      0: begin actA = {8'h00, if16.a}; actPc = if16.page_cross; end
      1: begin actA = {8'h00, if3.a}; actPc = if3.page_cross; end
      default: begin actA = if24.a; actPc = if24.page_cross; end
    endcase
    compareCount++;
    if (actA !== e.expA || actPc !== e.expPc) begin
      failCount++;
      $display("[TB] FAIL %s: got a=%h pc=%b, expected a=%h pc=%b", e.name, actA, actPc, e.expA, e.expPc);
    end
  endtask

  // Monitor: outputs settle after the falling edge, so compare on the rising edge.
  always @(posedge clk) begin
    while (expQ.size() > 0) begin
      curEntry = expQ.pop_front();
      checkOutput(curEntry);
    end
  end

  initial begin
    int unsigned modelA;
    int unsigned modelPc;
    int unsigned src;
    logic [1:0] rMode;
    logic [2:0] rSel;
    logic [7:0] rIdx;
    logic rRst;

    compareCount = 0;
    failCount    = 0;
    rstN   = 1'b0;
    srcBus = '0;
    if16.mode = 2'b01; if16.addr_sel = '0; if16.idx = '0; if16.addr_in = '0;
    if3.mode  = 2'b01; if3.addr_sel  = '0; if3.idx  = '0; if3.addr_in  = '0;
    if24.mode = 2'b01; if24.addr_sel = '0; if24.idx = '0; if24.addr_in = '0;

    applyStimulus(0, 3'd0, 2'b01, 8'h00, 1'b0, 24'h0000, 1'b0, "reset16");
    applyStimulus(2, 3'd0, 2'b01, 8'h00, 1'b0, 24'h0000, 1'b0, "reset24");

    // Reset wins over an INC on the same edge.
    srcBus[63:0] = {16'h0, 16'h0, 16'h0, 16'h12FF};
    applyStimulus(0, 3'd0, 2'b00, 8'h00, 1'b1, 24'h12FF, 1'b0, "load12FF");
    applyStimulus(0, 3'd0, 2'b10, 8'h00, 1'b0, 24'h0000, 1'b0, "resetMidInc");

    srcBus[63:0] = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    applyStimulus(0, 3'd0, 2'b00, 8'h00, 1'b1, 24'hAAAA, 1'b0, "loadSrc0");
    applyStimulus(0, 3'd1, 2'b00, 8'h00, 1'b1, 24'hBBBB, 1'b0, "loadSrc1");
    applyStimulus(0, 3'd2, 2'b00, 8'h00, 1'b1, 24'hCCCC, 1'b0, "loadSrc2");
    applyStimulus(0, 3'd3, 2'b00, 8'h00, 1'b1, 24'hDDDD, 1'b0, "loadSrc3");
    applyStimulus(1, 3'd0, 2'b00, 8'h00, 1'b1, 24'hAAAA, 1'b0, "nsrc3Sel0");
    applyStimulus(1, 3'd3, 2'b00, 8'h00, 1'b1, 24'hCCCC, 1'b0, "nsrc3Fallthrough");

    srcBus[63:0] = {16'h0, 16'h0, 16'hFFFF, 16'h00FE};
    applyStimulus(0, 3'd0, 2'b00, 8'h00, 1'b1, 24'h00FE, 1'b0, "load00FE");
    applyStimulus(0, 3'd3, 2'b10, 8'h00, 1'b1, 24'h00FF, 1'b0, "inc00FF");
    applyStimulus(0, 3'd2, 2'b10, 8'h00, 1'b1, 24'h0100, 1'b1, "incPageCross");
    applyStimulus(0, 3'd1, 2'b10, 8'h00, 1'b1, 24'h0101, 1'b0, "incAfterCross");
    applyStimulus(0, 3'd1, 2'b00, 8'h00, 1'b1, 24'hFFFF, 1'b0, "loadFFFF");
    applyStimulus(0, 3'd0, 2'b10, 8'h00, 1'b1, 24'h0000, 1'b1, "incWrap");

    srcBus[63:0] = {16'h0, 16'h0, 16'hFFFF, 16'h20F0};
    applyStimulus(0, 3'd0, 2'b11, 8'h0F, 1'b1, 24'h20FF, 1'b0, "indexNoCross");
    applyStimulus(0, 3'd1, 2'b11, 8'h01, 1'b1, 24'h0000, 1'b1, "indexWrap");
    applyStimulus(0, 3'd0, 2'b11, 8'h10, 1'b1, 24'h2100, 1'b1, "indexCross");

    for (int n = 0; n < 5; n++) begin
      srcBus[63:0] = {4{16'(16'h1111 * (n + 1))}};
      applyStimulus(0, 3'(n), 2'b01, 8'hFF, 1'b1, 24'h2100, 1'b0, "holdStable");
    end

    srcBus = '0;
    srcBus[23:0] = 24'h01FFF0;
    applyStimulus(2, 3'd0, 2'b11, 8'h20, 1'b1, 24'h020010, 1'b1, "index24");

    // Reference-model stream on the 24-bit instance.
    modelA = 32'h020010;
    modelPc = 0;
    for (int n = 0; n < 10000; n++) begin
      rMode = 2'($urandom_range(0, 3));
      rSel  = 3'($urandom_range(0, 7));
      rIdx  = 8'($urandom);
      rRst  = ($urandom_range(0, 49) != 0);
      if (n % 4 == 0) begin
        for (int k = 0; k < 8; k++) srcBus[k*24 +: 24] = 24'($urandom);
      end
      src = 32'(srcBus[int'(rSel)*24 +: 24]);
      if (!rRst) begin
        modelA = 0; modelPc = 0;
      end else if (rMode == 2'b00) begin
        modelA = src; modelPc = 0;
      end else if (rMode == 2'b01) begin
        modelPc = 0;
      end else if (rMode == 2'b10) begin
        modelPc = ((modelA % 256) == 255) ? 1 : 0;
        modelA  = (modelA + 1) % 32'h1000000;
      end else begin
        modelPc = (((src % 256) + rIdx) > 255) ? 1 : 0;
        modelA  = (src + rIdx) % 32'h1000000;
      end
      applyStimulus(2, rSel, rMode, rIdx, rRst, 24'(modelA), modelPc[0], "random24");
    end

    rstN = 1'b1;
    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
